if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 104 ++++++++++
 tb/tb_if_id_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF stage PC register and IF/ID pipeline register with stall/flush handling and event counters.
// One-edge latency from Instr_i to ID_instr_o; stall holds IF/ID, flush squashes it; start_i=0 freezes everything.
module if_id_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PCWrite_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] Branch_target_i,
  input  logic [31:0] Instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ID_pc_o,
  output logic [31:0] ID_instr_o,
  output logic        ID_valid_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
  output logic        proto_err_o
);

  logic        stall_eff;
  logic        flush_eff;

  logic [31:0] pc_d,        pc_q;
  logic [31:0] id_pc_d,     id_pc_q;
  logic [31:0] id_instr_d,  id_instr_q;
  logic        id_valid_d,  id_valid_q;
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] flush_cnt_d, flush_cnt_q;
  logic        proto_err_d, proto_err_q;

  // Stall outranks flush: a stalled ID stage cannot resolve its branch this cycle.
  assign stall_eff = start_i & Stall_i;
  assign flush_eff = start_i & Flush_i & ~Stall_i;

  always_comb begin
    pc_d = pc_q;
    if (flush_eff) begin
      pc_d = Branch_target_i;
    end else if (start_i && PCWrite_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (flush_eff) begin
      id_pc_d    = 32'h0;
      id_instr_d = 32'h0;
      id_valid_d = 1'b0;
    end else if (start_i && !stall_eff) begin
      id_pc_d    = pc_q;
      id_instr_d = Instr_i;
      id_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    proto_err_d = proto_err_q;
    if (stall_eff && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_eff && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
    // Hazard unit should always drive PCWrite_i as the inverse of Stall_i.
    if (start_i && (PCWrite_i == Stall_i)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= 32'h0;
      id_pc_q     <= 32'h0;
      id_instr_q  <= 32'h0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
      proto_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign pc_o        = pc_q;
  assign ID_pc_o     = id_pc_q;
  assign ID_instr_o  = id_instr_q;
  assign ID_valid_o  = id_valid_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; instruction memory returns pc ^ 32'hA5A5_0000.
`timescale 1ns/1ps
module tb_if_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        PCWrite_i;
  logic        Stall_i;
  logic        Flush_i;
  logic [31:0] Branch_target_i;
  logic [31:0] Instr_i;
  logic [31:0] pc_o;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_instr_o;
  logic        ID_valid_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic        proto_err_o;

  int n_cmp = 0;
  int n_err = 0;

  if_id_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
    .Stall_i(Stall_i), .Flush_i(Flush_i), .Branch_target_i(Branch_target_i),
    .Instr_i(Instr_i), .pc_o(pc_o), .ID_pc_o(ID_pc_o), .ID_instr_o(ID_instr_o),
    .ID_valid_o(ID_valid_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  assign Instr_i = pc_o ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic st, input logic pcw, input logic stl, input logic fl);
    start_i   = st;
    PCWrite_i = pcw;
    Stall_i   = stl;
    Flush_i   = fl;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] idpc,
                         input logic [31:0] idin, input logic vld, input logic [15:0] sc,
                         input logic [15:0] fc, input logic perr);
    chk({tag, ".pc"},    pc_o,        pc);
    chk({tag, ".idpc"},  ID_pc_o,     idpc);
    chk({tag, ".instr"}, ID_instr_o,  idin);
    chk({tag, ".vld"},   {31'b0, ID_valid_o},  {31'b0, vld});
    chk({tag, ".scnt"},  {16'b0, stall_cnt_o}, {16'b0, sc});
    chk({tag, ".fcnt"},  {16'b0, flush_cnt_o}, {16'b0, fc});
    chk({tag, ".perr"},  {31'b0, proto_err_o}, {31'b0, perr});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    Branch_target_i = 32'h0;
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Free run, three edges.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    chk_all("run3", 32'd12, 32'd8, 32'hA5A5_0008, 1'b1, 16'd0, 16'd0, 1'b0);

    // Load-use stall at pc=8.
    do_reset();
    repeat (2) step();
    chk("pre_stall.pc", pc_o, 32'd8);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("stall", 32'd8, 32'd4, 32'hA5A5_0004, 1'b1, 16'd1, 16'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("post_stall", 32'd12, 32'd8, 32'hA5A5_0008, 1'b1, 16'd1, 16'd0, 1'b0);
    step();
    chk("pre_flush.pc", pc_o, 32'd16);

    // Flush to 0x40.
    Branch_target_i = 32'h40;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("flush", 32'h40, 32'h0, 32'h0, 1'b0, 16'd1, 16'd1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("post_flush", 32'h44, 32'h40, 32'hA5A5_0040, 1'b1, 16'd1, 16'd1, 1'b0);

    // Stall and flush together: stall wins.
    Branch_target_i = 32'h100;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("stall_flush", 32'h44, 32'h40, 32'hA5A5_0040, 1'b1, 16'd2, 16'd1, 1'b0);

    // start_i=0 freezes everything, including error detection.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) step();
    chk_all("frozen", 32'h44, 32'h40, 32'hA5A5_0040, 1'b1, 16'd2, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("frozen_fl", 32'h44, 32'h40, 32'hA5A5_0040, 1'b1, 16'd2, 16'd1, 1'b0);

    // PCWrite and Stall both high: sticky error, PC advances, IF/ID held.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("proto", 32'h48, 32'h40, 32'hA5A5_0040, 1'b1, 16'd3, 16'd1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("proto_run", 32'h4C, 32'h48, 32'hA5A5_0048, 1'b1, 16'd3, 16'd1, 1'b1);
    Branch_target_i = 32'h200;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("proto_flush", 32'h200, 32'h0, 32'h0, 1'b0, 16'd3, 16'd2, 1'b1);

    // Reset mid-stall, then fetch resumes from 0.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("after_rst", 32'h4, 32'h0, 32'hA5A5_0000, 1'b1, 16'd0, 16'd0, 1'b0);

    // PC wrap from 0xFFFF_FFFC.
    Branch_target_i = 32'hFFFF_FFFC;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("wrap_pre.pc", pc_o, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1, 16'd0, 16'd1, 1'b0);

    // Stall counter saturation.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (65534) @(posedge clk_i);
    #1;
    chk("sat_m1", {16'b0, stall_cnt_o}, 32'h0000_FFFE);
    repeat (1) @(posedge clk_i);
    #1;
    chk("sat_at", {16'b0, stall_cnt_o}, 32'h0000_FFFF);
    repeat (70000 - 65535) @(posedge clk_i);
    #1;
    chk_all("sat", 32'h0, 32'h0, 32'h0, 1'b0, 16'hFFFF, 16'd0, 1'b0);

    // Asynchronous reset between edges clears immediately.
    #2;
    rst_i = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
